// File: rtl/pipelined_adder.sv
// Valid/ready add/subtract/accumulate unit with a STAGES-deep result pipe.
// Mode is resolved at acceptance; the pipe only carries valid + result.

module pipelined_adder_stage #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         vin,
  input  logic [W-1:0] din,
  output logic         vout,
  output logic [W-1:0] dout
);
  // Data only loads on a valid beat, so a bubble leaves the last result in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout <= 1'b0;
      dout <= '0;
    end else if (adv) begin
      vout <= vin;
      if (vin) dout <= din;
    end
  end
endmodule

module pipelined_adder #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic [4:0]       occupancy
);
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][WIDTH:0] res_pipe;
  logic [WIDTH:0]           ea, eb, acc, acc_nxt, res;
  logic                     rdy_en, adv, fire, consume;

  assign ea      = {1'b0, a};
  assign eb      = {1'b0, b};
  assign adv     = !(vld_pipe[STAGES] && !out_ready);
  assign in_ready = rdy_en && adv;
  assign fire    = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    res     = '0;
    acc_nxt = acc;
    case (mode)
      2'b00: res = ea + eb;
      2'b01: res = ea - eb;
      2'b10: begin
        acc_nxt = acc + ea;
        res     = acc_nxt;
      end
      default: begin
        acc_nxt = '0;
        res     = '0;
      end
    endcase
  end

  // rdy_en keeps in_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en    <= 1'b0;
      acc       <= '0;
      occupancy <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (fire && mode[1]) acc <= acc_nxt;
      case ({fire, consume})
        2'b10:   occupancy <= occupancy + 5'd1;
        2'b01:   occupancy <= occupancy - 5'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign vld_pipe[0] = fire;
  assign res_pipe[0] = res;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    pipelined_adder_stage #(.W(WIDTH+1)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .adv  (adv),
      .vin  (vld_pipe[s]),
      .din  (res_pipe[s]),
      .vout (vld_pipe[s+1]),
      .dout (res_pipe[s+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = res_pipe[STAGES];
endmodule
